// File: rtl/fetch_assembler.sv
// fetch_assembler: byte-serial instruction fetch sequencer.
// Reads one byte per memory handshake, packs bytes MSB-first into a 32-bit
// word and strobes it out with its length code. Owns the program counter.
module fetch_assembler #(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic [7:0]        opcode,
  input  logic [1:0]        op_len,
  output logic [31:0]       raw,
  output logic [1:0]        len,
  output logic              we,
  output logic              busy,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [2:0] {IDLE, B0, B1, B2, B3, DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc_nx;
  logic [31:0]       raw_nx;
  logic [1:0]        len_nx;

  // Place a byte into its MSB-first lane of the word being assembled.
  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    case (idx)
      2'd0:    w[31:24] = b;
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      default: w[7:0]   = b;
    endcase
    return w;
  endfunction

  // Byte lane served by each byte-fetch state.
  function automatic logic [1:0] lane_of(input state_t s);
    case (s)
      B1:      return 2'd1;
      B2:      return 2'd2;
      B3:      return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Following byte-fetch state when the instruction is longer.
  function automatic state_t next_byte(input state_t s);
    case (s)
      B0:      return B1;
      B1:      return B2;
      default: return B3;
    endcase
  endfunction

  // The length decoder sees the live byte while the first byte is arriving.
  assign opcode   = (state == B0) ? mem_data : raw[31:24];
  assign mem_addr = pc;
  assign mem_req  = (state == B0) || (state == B1) || (state == B2) || (state == B3);
  assign we       = (state == DONE);
  assign busy     = (state != IDLE);

  // Next-state, PC and word assembly; jump overrides everything except the DONE strobe.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    raw_nx   = raw;
    len_nx   = len;
    case (state)
      IDLE: begin
        if (fetch_en) begin
          raw_nx   = '0;
          state_nx = B0;
        end
      end
      B0, B1, B2, B3: begin
        if (mem_ack) begin
          raw_nx = insert_byte(raw, lane_of(state), mem_data);
          pc_nx  = pc + 1'b1;
          if (state == B0) len_nx = op_len;
          if (lane_of(state) == ((state == B0) ? op_len : len))
            state_nx = DONE;
          else
            state_nx = next_byte(state);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (jump) begin
      pc_nx    = jump_addr;
      state_nx = IDLE;
      raw_nx   = raw;
      len_nx   = len;
    end
  end

  // State, PC and assembled word registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      raw   <= '0;
      len   <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      raw   <= raw_nx;
      len   <= len_nx;
    end
  end

endmodule

// File: tb/tb_fetch_assembler.sv
// Directed bench for fetch_assembler with a wait-state memory model and a
// small opcode-length decoder.
module tb_fetch_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        jump;
  logic [15:0] jump_addr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [7:0]  opcode;
  logic [1:0]  op_len;
  logic [31:0] raw;
  logic [1:0]  len;
  logic        we;
  logic        busy;
  logic [15:0] pc;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mem [0:65535];
  int wait_cycles   = 0;
  int wcnt          = 0;
  int addr_unstable = 0;
  logic        prev_req  = 1'b0;
  logic        prev_ack  = 1'b0;
  logic [15:0] prev_addr = '0;

  fetch_assembler #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .jump(jump), .jump_addr(jump_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .opcode(opcode), .op_len(op_len), .raw(raw), .len(len), .we(we), .busy(busy), .pc(pc)
  );

  always #5 clk = ~clk;

  // Opcode-length decoder.
  function automatic logic [1:0] dec_len(input logic [7:0] op);
    case (op)
      8'h10:   return 2'd0;
      8'h5A:   return 2'd1;
      8'h7C:   return 2'd2;
      8'hA1:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction
  assign op_len = dec_len(opcode);

  // Memory: acks after wait_cycles idle cycles, driven on the falling edge.
  always @(negedge clk) begin
    if (prev_req && !prev_ack && mem_req && (mem_addr !== prev_addr)) addr_unstable++;
    prev_req  = mem_req;
    prev_addr = mem_addr;
    if (mem_req) begin
      if (wcnt >= wait_cycles) begin
        mem_ack  = 1'b1;
        mem_data = mem[mem_addr];
        wcnt     = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
    prev_ack = mem_ack;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic set_pc(input logic [15:0] a);
    jump = 1'b1;
    jump_addr = a;
    @(posedge clk); #1;
    jump = 1'b0;
  endtask

  // Launch a fetch and return at #1 into the cycle where we is high.
  task automatic run_fetch(output int cyc);
    bit seen;
    seen = 1'b0;
    fetch_en = 1'b1;
    @(posedge clk); #1;
    fetch_en = 1'b0;
    cyc = 1;
    while (!seen && cyc < 60) begin
      if (we) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("we_seen", 32'(seen), 32'd1);
  endtask

  task automatic back_to_idle(input string tag);
    @(posedge clk); #1;
    chk({tag, "_we_pulse"}, 32'(we), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc, t1, t2;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst = 1'b1; fetch_en = 1'b0; jump = 1'b0; jump_addr = '0;
    mem_ack = 1'b0; mem_data = '0;
    #12;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_raw", raw, 32'h0);
    chk("rst_len", 32'(len), 32'h0);
    chk("rst_we", 32'(we), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // 1-byte instruction
    mem[0] = 8'h10;
    run_fetch(cyc);
    chk("b1_lat", cyc, 2);
    chk("b1_raw", raw, 32'h1000_0000);
    chk("b1_len", 32'(len), 32'd0);
    chk("b1_pc", 32'(pc), 32'h1);
    back_to_idle("b1");

    // 4-byte instruction
    set_pc(16'h0000);
    mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;
    run_fetch(cyc);
    chk("b4_lat", cyc, 5);
    chk("b4_raw", raw, 32'hA1B2_C3D4);
    chk("b4_len", 32'(len), 32'd3);
    chk("b4_pc", 32'(pc), 32'h4);
    back_to_idle("b4");

    // 3-byte instruction, two wait cycles per byte
    set_pc(16'h0100);
    mem[16'h0100] = 8'h7C; mem[16'h0101] = 8'h11; mem[16'h0102] = 8'h22;
    wait_cycles = 2;
    addr_unstable = 0;
    run_fetch(cyc);
    chk("ws_lat", cyc, 10);
    chk("ws_raw", raw, 32'h7C11_2200);
    chk("ws_len", 32'(len), 32'd2);
    chk("ws_pc", 32'(pc), 32'h0103);
    chk("ws_addr_stable", addr_unstable, 0);
    back_to_idle("ws");
    wait_cycles = 0;

    // Abort with jump coincident with the second byte's ack
    set_pc(16'h0300);
    mem[16'h0300] = 8'hA1; mem[16'h0301] = 8'h01; mem[16'h0302] = 8'h02; mem[16'h0303] = 8'h03;
    fetch_en = 1'b1;
    @(posedge clk); #1;
    fetch_en = 1'b0;
    @(posedge clk); #1;
    jump = 1'b1; jump_addr = 16'h0200;
    @(posedge clk); #1;
    jump = 1'b0;
    chk("ab_we", 32'(we), 32'd0);
    chk("ab_pc", 32'(pc), 32'h0200);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_req", 32'(mem_req), 32'd0);
    chk("ab_raw", raw, 32'hA100_0000);
    chk("ab_len", 32'(len), 32'd3);
    mem[16'h0200] = 8'h10;
    run_fetch(cyc);
    chk("ab_next_raw", raw, 32'h1000_0000);
    chk("ab_next_pc", 32'(pc), 32'h0201);
    back_to_idle("ab");

    // PC wrap across the top of the address space
    set_pc(16'hFFFF);
    mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'hEE;
    run_fetch(cyc);
    chk("wr_lat", cyc, 3);
    chk("wr_raw", raw, 32'h5AEE_0000);
    chk("wr_len", 32'(len), 32'd1);
    chk("wr_pc", 32'(pc), 32'h0001);
    back_to_idle("wr");

    // Jump during DONE: strobe stands, PC reloads
    set_pc(16'h0020);
    mem[16'h0020] = 8'h10;
    run_fetch(cyc);
    chk("jd_we", 32'(we), 32'd1);
    jump = 1'b1; jump_addr = 16'h0400;
    @(posedge clk); #1;
    jump = 1'b0;
    chk("jd_pc", 32'(pc), 32'h0400);
    chk("jd_busy", 32'(busy), 32'd0);
    chk("jd_raw", raw, 32'h1000_0000);

    // Back-to-back 1-byte fetches with fetch_en held
    set_pc(16'h0000);
    for (int i = 0; i < 4; i++) mem[i] = 8'h10;
    t1 = -1; t2 = -1;
    fetch_en = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (we) begin
        if (t1 < 0) t1 = c;
        else if (t2 < 0) t2 = c;
      end
    end
    fetch_en = 1'b0;
    chk("bb_first", t1, 2);
    chk("bb_interval", t2 - t1, 3);
    chk("bb_pc", 32'(pc), 32'h4);
    chk("bb_idle", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a fetch
    set_pc(16'h0010);
    mem[16'h0010] = 8'hA1;
    fetch_en = 1'b1;
    @(posedge clk); #1;
    fetch_en = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("ar_pc", 32'(pc), 32'h0);
    chk("ar_req", 32'(mem_req), 32'd0);
    chk("ar_we", 32'(we), 32'd0);
    chk("ar_raw", raw, 32'h0);
    chk("ar_busy", 32'(busy), 32'd0);
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ar_after_busy", 32'(busy), 32'd0);
    chk("ar_after_pc", 32'(pc), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
